z80_bus_tracer: RTL and testbench
=================================

Name: z80_bus_tracer

Overview:
- Passive Z80 bus-cycle capture engine for the CPU card's probe header. Replaces manual probing with a recorded cycle log.
- Samples the Z80 pins on a fast system clock, classifies each bus cycle and records {type, address, data}.
- Buffers records in a first-word-fall-through FIFO that a host drains through a valid/ready port.
- Counts and flags cycles lost to a full FIFO.

Parameters:
- ADDR_W, 16: address width.
- DATA_W, 8: data width.
- DEPTH, 16: FIFO records, power of two, >=2.
- SYNC_STAGES, 2: synchroniser flops per bus input, >=2.
- OVF_W, 8: overflow counter width.

Ports:
- CLK  in  1  system sampling clock, >=4x Z80 clock.
- RESET_B  in  1  asynchronous active-low reset.
- en  in  1  arm capture.
- clr  in  1  synchronous flush of FIFO and overflow state.
- A  in  ADDR_W  Z80 address bus, asynchronous.
- D  in  DATA_W  Z80 data bus, asynchronous.
- MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B  in  1 each  Z80 controls, asynchronous.
- rec_valid  out  1  head record available.
- rec_ready  in  1  host pops the head record.
- rec_type  out  3  cycle type of head record.
- rec_addr  out  ADDR_W  address of head record.
- rec_data  out  DATA_W  data of head record.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- ovf_cnt  out  OVF_W  lost cycles, saturating.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Clock and reset: single clock CLK; reset is asynchronous and active-low on RESET_B.
- Input synchronisation: every bus input passes through SYNC_STAGES flops. All rules below use the synced values, written with an s_ prefix.
- Definitions:
  - req = (!s_MREQ_B & s_RFSH_B) | !s_IOREQ_B. Refresh cycles are never recorded.
  - strobe = !s_RD_B | !s_WR_B | (!s_M1_B & !s_IOREQ_B).
- Cycle-type encoding, decided on the first cycle strobe is seen (priority top-down):
  - 5 = INTA: M1 & IOREQ.
  - 0 = opcode fetch: M1 & MREQ & RD.
  - 1 = memory read: MREQ & RD.
  - 2 = memory write: MREQ & WR.
  - 3 = IO read: IOREQ & RD.
  - 4 = IO write: IOREQ & WR.
  - 6 and 7 are reserved and never generated.
- FSM:
  - IDLE: if en & req & strobe, latch s_A, latch type, latch s_D into the data register, then go to ACTIVE.
  - ACTIVE: while strobe, reload the data register from s_D every cycle, so the last value before strobe release is kept. On !strobe, go to COMMIT.
  - COMMIT (one cycle): if not full, push the record; else ovf_cnt += 1 (saturating at all-ones) and ovf = 1. Go to WAIT.
  - WAIT: stay until !req, then go to IDLE. This guarantees one record per bus cycle.
- en: sampled in IDLE only. Deasserting en mid-cycle lets the current record complete.
- Latency: with the FIFO empty, rec_valid rises on the SYNC_STAGES+2 edge after the first CLK edge that samples raw strobe released.
- FIFO:
  - First-word fall-through; rec_* show the head whenever rec_valid = 1.
  - A pop occurs when rec_valid & rec_ready.
  - Simultaneous push and pop when full: both happen, level unchanged, no overflow.
  - Push when empty with rec_ready high: the record appears next cycle and is not popped in the same cycle.
  - Read and write pointers wrap modulo DEPTH.
- clr: empties the FIFO, zeroes ovf_cnt and ovf, forces the FSM to WAIT. clr wins over a concurrent push or pop.
- Reset values:
  - rec_valid = 0, level = 0, ovf_cnt = 0, ovf = 0.
  - rec_type, rec_addr, rec_data = 0.
  - FSM = IDLE; synchroniser flops load the idle-bus value (controls = 1).
  - Reset asserted mid-cycle discards the partial record.

Optional Feature:
- Macro: ZTRACE_WINDOW_EN.
- When defined:
  - Adds inputs win_lo and win_hi, each ADDR_W wide.
  - Memory cycles (types 0-2) are recorded only if win_lo <= addr <= win_hi (unsigned, inclusive). A filtered cycle still passes through WAIT and is not counted as overflow.
  - Types 3-5 are always recorded.
  - If win_lo > win_hi, no memory cycles are recorded.
- When undefined: no extra ports, and every non-refresh cycle is recorded.

Test Plan:
1. Opcode fetch, M1 = MREQ = RD = 0, A = 0x0038, D = 0xC3, then release -> one record, type 0, addr 0x0038, data 0xC3. rec_valid rises at the SYNC_STAGES+2 latency.
2. Memory write A = 0xC000, D = 0x5A, followed by a refresh cycle with RFSH = MREQ = 0 -> exactly one record, type 2, addr 0xC000, data 0x5A; level = 1.
3. INTA (M1 = IOREQ = 0, D = 0xFF), then IO write A = 0x7F10, D = 0x8C -> records {5, x, 0xFF} then {4, 0x7F10, 0x8C}, in order.
4. rec_ready held low, DEPTH+3 = 19 memory reads -> level = 16, ovf = 1, ovf_cnt = 3. Draining returns the first 16 cycles in order. Then clr -> level 0, ovf 0, ovf_cnt 0.
5. FIFO full, with a commit and a pop in the same cycle -> level stays 16, ovf_cnt unchanged. Assert RESET_B low during ACTIVE -> all outputs reach reset values and no record is produced.
6. With ZTRACE_WINDOW_EN, win = 0x4000..0x7FFF; reads at 0x3FFF, 0x4000, 0x7FFF, 0x8000 plus an IO read at 0x00FE -> records only for 0x4000, 0x7FFF and the IO read; ovf_cnt = 0.

Source files
------------

// File: rtl/z80_bus_tracer.sv
// Passive Z80 bus-cycle tracer: synchronises the bus pins, records one {type, addr, data}
// record per non-refresh cycle into a FWFT FIFO. Optional address window via ZTRACE_WINDOW_EN.
module z80_bus_tracer #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned OVF_W       = 8
) (
    input  logic                         CLK,
    input  logic                         RESET_B,
    input  logic                         en,
    input  logic                         clr,
    input  logic [ADDR_W-1:0]            A,
    input  logic [DATA_W-1:0]            D,
    input  logic                         MREQ_B,
    input  logic                         IOREQ_B,
    input  logic                         RD_B,
    input  logic                         WR_B,
    input  logic                         M1_B,
    input  logic                         RFSH_B,
`ifdef ZTRACE_WINDOW_EN
    input  logic [ADDR_W-1:0]            win_lo,
    input  logic [ADDR_W-1:0]            win_hi,
`endif
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [2:0]                   rec_type,
    output logic [ADDR_W-1:0]            rec_addr,
    output logic [DATA_W-1:0]            rec_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [OVF_W-1:0]             ovf_cnt,
    output logic                         ovf
);

    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned REC_W  = TYPE_W + ADDR_W + DATA_W;
    localparam int unsigned BUS_W  = ADDR_W + DATA_W + 6;
    localparam logic [BUS_W-1:0] SYNC_RST = {{(ADDR_W + DATA_W){1'b0}}, 6'b111111};

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_COMMIT, ST_WAIT} state_e;

    logic [BUS_W-1:0]  sync_q [SYNC_STAGES];
    logic [BUS_W-1:0]  sync_d [SYNC_STAGES];
    logic [ADDR_W-1:0] s_a;
    logic [DATA_W-1:0] s_d;
    logic              s_mreq_b, s_ioreq_b, s_rd_b, s_wr_b, s_m1_b, s_rfsh_b;
    logic              req, strobe, keep;
    logic [TYPE_W-1:0] cyc_type;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              push_q, push_d;

    logic [REC_W-1:0]  mem_q [DEPTH];
    logic [REC_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic              ovf_q, ovf_d;
    logic              rec_valid_q, rec_valid_d;
    logic [REC_W-1:0]  head_q, head_d;
    logic [REC_W-1:0]  push_rec;
    logic              pop, full, wr_en, lost;

    // Synchroniser chain; every bus pin travels together so a sample is self-consistent.
    always_comb begin
        sync_d[0] = {A, D, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign {s_a, s_d, s_mreq_b, s_ioreq_b, s_rd_b, s_wr_b, s_m1_b, s_rfsh_b} = sync_q[SYNC_STAGES-1];

    assign req    = (!s_mreq_b && s_rfsh_b) || !s_ioreq_b;
    assign strobe = !s_rd_b || !s_wr_b || (!s_m1_b && !s_ioreq_b);

    always_comb begin
        cyc_type = 3'd1;
        if (!s_m1_b && !s_ioreq_b)                 cyc_type = 3'd5;
        else if (!s_m1_b && !s_mreq_b && !s_rd_b)  cyc_type = 3'd0;
        else if (!s_mreq_b && !s_rd_b)             cyc_type = 3'd1;
        else if (!s_mreq_b && !s_wr_b)             cyc_type = 3'd2;
        else if (!s_ioreq_b && !s_rd_b)            cyc_type = 3'd3;
        else if (!s_ioreq_b && !s_wr_b)            cyc_type = 3'd4;
    end

`ifdef ZTRACE_WINDOW_EN
    // Memory cycles outside the inclusive window are dropped; an inverted window drops them all.
    assign keep = (type_q > 3'd2) || ((addr_q >= win_lo) && (addr_q <= win_hi));
`else
    assign keep = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        data_d  = data_q;
        push_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && req && strobe) begin
                    addr_d  = s_a;
                    type_d  = cyc_type;
                    data_d  = s_d;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (strobe) data_d  = s_d;
                else        state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                push_d  = keep;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d = ST_WAIT;
            push_d  = 1'b0;
        end
    end

    // FIFO: push_q is the registered commit, so the full check sees the same cycle's pop.
    always_comb begin
        pop         = rec_valid_q && rec_ready;
        full        = (level_q == LVL_W'(DEPTH));
        wr_en       = push_q && (!full || pop);
        lost        = push_q && full && !pop;
        push_rec    = {type_q, addr_q, data_q};
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        ovf_cnt_d   = ovf_cnt_q;
        ovf_d       = ovf_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_rec;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_en && !pop)      level_d = level_q + LVL_W'(1);
        else if (!wr_en && pop) level_d = level_q - LVL_W'(1);
        if (lost) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
        end
        if (wr_en && (level_q == LVL_W'(pop))) head_d = push_rec;
        else                                   head_d = mem_q[rd_ptr_d];
        rec_valid_d = (level_d != '0);
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            ovf_cnt_d   = '0;
            ovf_d       = 1'b0;
            head_d      = '0;
            rec_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            for (int unsigned i = 0; i < DEPTH; i++)       mem_q[i]  <= '0;
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            type_q      <= '0;
            data_q      <= '0;
            push_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            rec_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            sync_q      <= sync_d;
            mem_q       <= mem_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            type_q      <= type_d;
            data_q      <= data_d;
            push_q      <= push_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_cnt_q   <= ovf_cnt_d;
            ovf_q       <= ovf_d;
            rec_valid_q <= rec_valid_d;
            head_q      <= head_d;
        end
    end

    assign rec_valid                      = rec_valid_q;
    assign {rec_type, rec_addr, rec_data} = head_q;
    assign level                          = level_q;
    assign ovf_cnt                        = ovf_cnt_q;
    assign ovf                            = ovf_q;

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Bench for z80_bus_tracer: table-driven bus cycles plus hand-written overflow, latency,
// clear and reset sequences, all checked against a queue of expected records.
module tb_z80_bus_tracer;

    localparam int unsigned SYNC = 2;
    localparam int K_OPF = 0, K_MRD = 1, K_MWR = 2, K_IORD = 3, K_IOWR = 4, K_INTA = 5, K_RFSH = 6;

    logic        CLK = 1'b0;
    logic        RESET_B, en, clr, rec_ready;
    logic [15:0] A;
    logic [7:0]  D;
    logic        MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B;
    logic        rec_valid, ovf;
    logic [2:0]  rec_type;
    logic [15:0] rec_addr;
    logic [7:0]  rec_data;
    logic [4:0]  level;
    logic [7:0]  ovf_cnt;
`ifdef ZTRACE_WINDOW_EN
    logic [15:0] win_lo, win_hi;
`endif

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] a;
        logic [7:0]  d;
    } rec_t;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rec;
        logic [2:0]  typ;
    } vec_t;

    rec_t sb[$];
    vec_t vt[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    z80_bus_tracer #(.ADDR_W(16), .DATA_W(8), .DEPTH(16), .SYNC_STAGES(SYNC), .OVF_W(8)) dut (
        .CLK(CLK), .RESET_B(RESET_B), .en(en), .clr(clr), .A(A), .D(D),
        .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B), .RFSH_B(RFSH_B),
`ifdef ZTRACE_WINDOW_EN
        .win_lo(win_lo), .win_hi(win_hi),
`endif
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type), .rec_addr(rec_addr),
        .rec_data(rec_data), .level(level), .ovf_cnt(ovf_cnt), .ovf(ovf)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time expired before completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_assert(input int kind, input logic [15:0] addr, input logic [7:0] data);
        A = addr;
        D = data;
        tick(1);
        case (kind)
            K_OPF:  begin M1_B = 1'b0; MREQ_B = 1'b0; RD_B = 1'b0; end
            K_MRD:  begin MREQ_B = 1'b0; RD_B = 1'b0; end
            K_MWR:  begin MREQ_B = 1'b0; WR_B = 1'b0; end
            K_IORD: begin IOREQ_B = 1'b0; RD_B = 1'b0; end
            K_IOWR: begin IOREQ_B = 1'b0; WR_B = 1'b0; end
            K_INTA: begin M1_B = 1'b0; IOREQ_B = 1'b0; end
            default: begin MREQ_B = 1'b0; RFSH_B = 1'b0; end
        endcase
    endtask

    task automatic bus_release();
        {MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B} = 6'b111111;
        D = ~D;
    endtask

    // Data bus starts wrong and settles mid-strobe: the last value before release must be kept.
    task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] data);
        bus_assert(kind, addr, ~data);
        tick(3);
        D = data;
        tick(4);
        bus_release();
        tick(8);
    endtask

    task automatic expect_rec(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d);
        rec_t r;
        r.t = t; r.a = a; r.d = d;
        sb.push_back(r);
    endtask

    task automatic drain(input int n);
        rec_t e;
        int   w;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!rec_valid && w < 100) begin
                tick(1);
                w++;
            end
            if (!rec_valid) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain_timeout: rec_valid got 0 want 1 (record %0d)", k);
                return;
            end
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got record addr 0x%0h want none", rec_addr);
            end else begin
                e = sb.pop_front();
                check("rec_type", 32'(rec_type), 32'(e.t));
                check("rec_addr", 32'(rec_addr), 32'(e.a));
                check("rec_data", 32'(rec_data), 32'(e.d));
            end
            rec_ready = 1'b1;
            tick(1);
            rec_ready = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rec_valid"}, 32'(rec_valid), 32'd0);
        check({tag, "_level"},     32'(level),     32'd0);
        check({tag, "_ovf"},       32'(ovf),       32'd0);
        check({tag, "_ovf_cnt"},   32'(ovf_cnt),   32'd0);
        check({tag, "_rec_type"},  32'(rec_type),  32'd0);
        check({tag, "_rec_addr"},  32'(rec_addr),  32'd0);
        check({tag, "_rec_data"},  32'(rec_data),  32'd0);
    endtask

    initial begin
        int nrec;
        vt[0] = '{K_OPF,  16'h0100, 8'h3E, 1'b1, 3'd0};
        vt[1] = '{K_MRD,  16'h8123, 8'hA5, 1'b1, 3'd1};
        vt[2] = '{K_RFSH, 16'h0040, 8'h00, 1'b0, 3'd0};
        vt[3] = '{K_MWR,  16'hFFFF, 8'h00, 1'b1, 3'd2};
        vt[4] = '{K_INTA, 16'h1234, 8'hFF, 1'b1, 3'd5};
        vt[5] = '{K_IOWR, 16'h7F10, 8'h8C, 1'b1, 3'd4};
        vt[6] = '{K_IORD, 16'h00FE, 8'h42, 1'b1, 3'd3};
        vt[7] = '{K_MRD,  16'h0000, 8'h81, 1'b1, 3'd1};

        RESET_B = 1'b0; en = 1'b1; clr = 1'b0; rec_ready = 1'b0;
        A = '0; D = '0;
        {MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B} = 6'b111111;
`ifdef ZTRACE_WINDOW_EN
        win_lo = 16'h0000; win_hi = 16'hFFFF;
`endif
        tick(3);
        check_reset_outputs("reset");
        RESET_B = 1'b1;
        tick(2);

        // Opcode fetch with exact release-to-valid latency
        bus_assert(K_OPF, 16'h0038, 8'h00);
        tick(3);
        D = 8'hC3;
        tick(4);
        bus_release();
        expect_rec(3'd0, 16'h0038, 8'hC3);
        tick(SYNC + 2);
        check("latency_early_valid", 32'(rec_valid), 32'd0);
        tick(1);
        check("latency_valid", 32'(rec_valid), 32'd1);
        check("latency_level", 32'(level), 32'd1);
        drain(1);

        // Memory write followed by a refresh: exactly one record
        bus_cycle(K_MWR, 16'hC000, 8'h5A);
        bus_cycle(K_RFSH, 16'h0041, 8'h00);
        expect_rec(3'd2, 16'hC000, 8'h5A);
        check("wr_rfsh_level", 32'(level), 32'd1);
        drain(1);

        // Table of mixed cycles, drained in order afterwards
        nrec = 0;
        for (int i = 0; i < 8; i++) begin
            bus_cycle(vt[i].kind, vt[i].addr, vt[i].data);
            if (vt[i].rec) begin
                expect_rec(vt[i].typ, vt[i].addr, vt[i].data);
                nrec++;
            end
        end
        check("table_level", 32'(level), 32'(nrec));
        drain(nrec);

        // Disarmed capture records nothing
        en = 1'b0;
        bus_cycle(K_MRD, 16'h5555, 8'h11);
        check("disarmed_level", 32'(level), 32'd0);
        en = 1'b1;

        // Overflow: 19 reads into a 16-deep FIFO
        for (int i = 0; i < 19; i++) begin
            bus_cycle(K_MRD, 16'h1000 + 16'(i), 8'(i * 7 + 1));
            if (i < 16) expect_rec(3'd1, 16'h1000 + 16'(i), 8'(i * 7 + 1));
        end
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_flag", 32'(ovf), 32'd1);
        check("ovf_cnt", 32'(ovf_cnt), 32'd3);
        drain(16);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Clear flushes records and overflow state
        bus_cycle(K_MRD, 16'h2000, 8'h01);
        bus_cycle(K_MRD, 16'h2001, 8'h02);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_level", 32'(level), 32'd0);
        check("clr_valid", 32'(rec_valid), 32'd0);
        check("clr_ovf", 32'(ovf), 32'd0);
        check("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
        tick(4);

        // Full FIFO: push and pop land on the same edge
        for (int i = 0; i < 16; i++) begin
            bus_cycle(K_MRD, 16'h3000 + 16'(i), 8'(8'hA0 + 8'(i)));
            expect_rec(3'd1, 16'h3000 + 16'(i), 8'(8'hA0 + 8'(i)));
        end
        check("full_level", 32'(level), 32'd16);
        bus_assert(K_MRD, 16'h3ABC, 8'h00);
        tick(3);
        D = 8'h77;
        tick(4);
        bus_release();
        tick(4);
        check("full_head_addr", 32'(rec_addr), 32'(sb[0].a));
        rec_ready = 1'b1;
        tick(1);
        rec_ready = 1'b0;
        void'(sb.pop_front());
        expect_rec(3'd1, 16'h3ABC, 8'h77);
        check("pushpop_level", 32'(level), 32'd16);
        check("pushpop_ovf_cnt", 32'(ovf_cnt), 32'd0);
        check("pushpop_ovf", 32'(ovf), 32'd0);
        tick(8);
        drain(16);

        // Reset during an active cycle discards the partial record
        bus_assert(K_MWR, 16'h4444, 8'h99);
        tick(5);
        RESET_B = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus_release();
        tick(3);
        RESET_B = 1'b1;
        tick(12);
        check("midrst_no_record", 32'(level), 32'd0);
        check("midrst_no_valid", 32'(rec_valid), 32'd0);

`ifdef ZTRACE_WINDOW_EN
        // Address window on memory cycles; IO always passes
        win_lo = 16'h4000; win_hi = 16'h7FFF;
        bus_cycle(K_MRD, 16'h3FFF, 8'h01);
        bus_cycle(K_MRD, 16'h4000, 8'h02);
        bus_cycle(K_MRD, 16'h7FFF, 8'h03);
        bus_cycle(K_MRD, 16'h8000, 8'h04);
        bus_cycle(K_IORD, 16'h00FE, 8'h05);
        expect_rec(3'd1, 16'h4000, 8'h02);
        expect_rec(3'd1, 16'h7FFF, 8'h03);
        expect_rec(3'd3, 16'h00FE, 8'h05);
        check("win_level", 32'(level), 32'd3);
        check("win_ovf_cnt", 32'(ovf_cnt), 32'd0);
        drain(3);
        win_lo = 16'h8000; win_hi = 16'h1000;
        bus_cycle(K_MRD, 16'h9000, 8'h06);
        bus_cycle(K_IOWR, 16'h0011, 8'h07);
        expect_rec(3'd4, 16'h0011, 8'h07);
        check("inv_win_level", 32'(level), 32'd1);
        drain(1);
`endif

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
